// File: rtl/fir_tdm_mac_if.sv
// Sample, coefficient and result signals of fir_tdm_mac.
// master drives samples/coefficients; slave is the filter.
interface fir_tdm_mac_if #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned COEF_WIDTH = 18,
  parameter int unsigned FIR_LENGTH = 128,
  parameter int unsigned NUM_CH     = 2
);
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AW  = $clog2(FIR_LENGTH);

  logic                  i_en;
  logic                  i_din_valid;
  logic                  o_din_ready;
  logic [DATA_WIDTH-1:0] i_din;
  logic [CHW-1:0]        i_din_ch;
  logic                  i_coef_we;
  logic [AW-1:0]         i_coef_addr;
  logic [COEF_WIDTH-1:0] i_coef_data;
  logic                  o_dout_valid;
  logic [DATA_WIDTH-1:0] o_dout;
  logic [CHW-1:0]        o_dout_ch;
  logic                  o_sum_overflow;
  logic                  o_busy;

  modport master (
    output i_en, i_din_valid, i_din, i_din_ch, i_coef_we, i_coef_addr, i_coef_data,
    input  o_din_ready, o_dout_valid, o_dout, o_dout_ch, o_sum_overflow, o_busy
  );

  modport slave (
    input  i_en, i_din_valid, i_din, i_din_ch, i_coef_we, i_coef_addr, i_coef_data,
    output o_din_ready, o_dout_valid, o_dout, o_dout_ch, o_sum_overflow, o_busy
  );
endinterface

// File: rtl/fir_tdm_mac.sv
// Multi-channel time-multiplexed FIR around one MAC, saturating output.
// Define FIR_ROUND_EN to round half up before the output shift.
module fir_tdm_mac #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned COEF_WIDTH = 18,
  parameter int unsigned FIR_LENGTH = 128,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned OUT_SHIFT  = 17
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fir_tdm_mac_if.slave  bus
);
  localparam int unsigned CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AW        = $clog2(FIR_LENGTH);
  localparam int unsigned ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + AW;
  localparam int unsigned PW        = DATA_WIDTH + COEF_WIDTH;
  localparam int unsigned EW        = ACC_WIDTH + 1;

  localparam logic signed [EW-1:0] SAT_MAX =
    {{(EW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {StClear, StIdle, StMac, StShift, StOut} state_e;

  state_e                        state_q;
  logic [CHW-1:0]                ch_q;
  logic [AW-1:0]                 k_q;
  logic [AW-1:0]                 wp_q [NUM_CH];
  logic [CHW-1:0]                clr_ch_q;
  logic [AW-1:0]                 clr_tap_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [DATA_WIDTH-1:0]  hist_q [NUM_CH][FIR_LENGTH];
  logic signed [COEF_WIDTH-1:0]  coef_q [FIR_LENGTH];

  logic                          ch_ok;
  logic [AW-1:0]                 wp_cur;
  logic [AW-1:0]                 rd_idx;
  logic signed [PW-1:0]          h_ext;
  logic signed [PW-1:0]          c_ext;
  logic signed [PW-1:0]          prod;
  logic signed [EW-1:0]          acc_ext;
  logic signed [EW-1:0]          acc_rnd;
  logic signed [EW-1:0]          shifted;
  logic [DATA_WIDTH-1:0]         sat_val;
  logic                          sat_ovf;

  // Out-of-range channel numbers only exist when NUM_CH is not a power of two.
  if ((1 << CHW) == NUM_CH) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_chk
    assign ch_ok = (32'(bus.i_din_ch) < NUM_CH);
  end

  assign bus.o_din_ready = (state_q == StIdle) && bus.i_en;
  assign bus.o_busy      = (state_q != StIdle);

  always_comb begin
    wp_cur = wp_q[ch_q];
    // Newest sample sits at wp; tap k looks k entries back, wrapping.
    if (wp_cur >= k_q) rd_idx = wp_cur - k_q;
    else               rd_idx = wp_cur - k_q + AW'(FIR_LENGTH);
    h_ext = {{COEF_WIDTH{hist_q[ch_q][rd_idx][DATA_WIDTH-1]}}, hist_q[ch_q][rd_idx]};
    c_ext = {{DATA_WIDTH{coef_q[k_q][COEF_WIDTH-1]}}, coef_q[k_q]};
    prod  = h_ext * c_ext;
  end

  always_comb begin
    acc_ext = {acc_q[ACC_WIDTH-1], acc_q};
`ifdef FIR_ROUND_EN
    if (OUT_SHIFT > 0) acc_rnd = acc_ext + (EW'(1) << (OUT_SHIFT - 1));
    else               acc_rnd = acc_ext;
`else
    acc_rnd = acc_ext;
`endif
    shifted = acc_rnd >>> OUT_SHIFT;
    sat_ovf = 1'b0;
    sat_val = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      sat_ovf = 1'b1;
      sat_val = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_ovf = 1'b1;
      sat_val = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q            <= StClear;
      ch_q               <= '0;
      k_q                <= '0;
      clr_ch_q           <= '0;
      clr_tap_q          <= '0;
      acc_q              <= '0;
      for (int i = 0; i < NUM_CH; i++) wp_q[i] <= '0;
      bus.o_dout_valid   <= 1'b0;
      bus.o_dout         <= '0;
      bus.o_dout_ch      <= '0;
      bus.o_sum_overflow <= 1'b0;
    end else if (bus.i_en) begin
      case (state_q)
        StClear: begin
          if (clr_tap_q == AW'(FIR_LENGTH - 1)) begin
            clr_tap_q <= '0;
            if (clr_ch_q == CHW'(NUM_CH - 1)) state_q <= StIdle;
            else                              clr_ch_q <= clr_ch_q + 1'b1;
          end else begin
            clr_tap_q <= clr_tap_q + 1'b1;
          end
        end
        StIdle: begin
          // Invalid channel: handshake completes, sample is discarded.
          if (bus.i_din_valid && ch_ok) begin
            ch_q    <= bus.i_din_ch;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_q + {{AW{prod[PW-1]}}, prod};
          if (k_q == AW'(FIR_LENGTH - 1)) begin
            k_q        <= '0;
            wp_q[ch_q] <= (wp_cur == AW'(FIR_LENGTH - 1)) ? '0 : wp_cur + 1'b1;
            state_q    <= StShift;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StShift: begin
          bus.o_dout         <= sat_val;
          bus.o_dout_ch      <= ch_q;
          bus.o_sum_overflow <= sat_ovf;
          bus.o_dout_valid   <= 1'b1;
          state_q            <= StOut;
        end
        StOut: begin
          bus.o_dout_valid   <= 1'b0;
          bus.o_sum_overflow <= 1'b0;
          state_q            <= StIdle;
        end
        default: state_q <= StClear;
      endcase
    end
  end

  // Storage needs no reset: CLEAR sweeps it after every reset.
  always_ff @(posedge i_clk) begin
    if (bus.i_en) begin
      if (state_q == StClear) begin
        hist_q[clr_ch_q][clr_tap_q] <= '0;
        if (clr_ch_q == '0) coef_q[clr_tap_q] <= '0;
      end else if (state_q == StIdle) begin
        if (bus.i_coef_we) coef_q[bus.i_coef_addr] <= bus.i_coef_data;
        if (bus.i_din_valid && ch_ok) hist_q[bus.i_din_ch][wp_q[bus.i_din_ch]] <= bus.i_din;
      end
    end
  end

endmodule
